// File: rtl/alu_decode_pipe.sv
// Handshaked ALU control decode + execute stage for the RISC-V datapath.
// Shifts run either as a barrel shift or one bit position per cycle.
module alu_decode_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SERIAL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             opb5,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [1:0]       ALUOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUControl,
  output logic             Zero,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam bit          SER = (SERIAL_SHIFT != 0);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_ctrl;
  logic             r_zero;
  logic             r_illegal;
  logic             r_out_valid;

  logic             w_accept;
  logic [3:0]       w_ctrl;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_go_serial;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_step;

  assign in_ready    = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
  assign w_accept    = in_valid & in_ready;
  assign w_shamt     = srcB[SHW-1:0];
  assign w_is_shift  = (w_ctrl == OP_SLL) | (w_ctrl == OP_SRL) | (w_ctrl == OP_SRA);
  assign w_go_serial = SER & w_is_shift & (w_shamt != '0);

  // Field decode into ALUControl
  always_comb begin
    w_ctrl = OP_ILL;
    case (ALUOp)
      2'b00: w_ctrl = OP_ADD;
      2'b01: w_ctrl = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  w_ctrl = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
          3'b001:  w_ctrl = OP_SLL;
          3'b010:  w_ctrl = OP_SLT;
          3'b011:  w_ctrl = OP_SLTU;
          3'b100:  w_ctrl = OP_XOR;
          3'b101:  w_ctrl = funct7b5 ? OP_SRA : OP_SRL;
          3'b110:  w_ctrl = OP_OR;
          default: w_ctrl = OP_AND;
        endcase
      end
      default: w_ctrl = OP_ILL;
    endcase
  end

  // Single-cycle result, including barrel shifts
  always_comb begin
    w_result = '0;
    case (w_ctrl)
      OP_ADD:  w_result = srcA + srcB;
      OP_SUB:  w_result = srcA - srcB;
      OP_AND:  w_result = srcA & srcB;
      OP_OR:   w_result = srcA | srcB;
      OP_XOR:  w_result = srcA ^ srcB;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SLL:  w_result = srcA << w_shamt;
      OP_SRL:  w_result = srcA >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(srcA) >>> w_shamt);
      default: w_result = '0;
    endcase
  end

  // One-position step of the serial shifter
  always_comb begin
    w_step = r_work;
    case (r_ctrl)
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
      default: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_ctrl      <= OP_ADD;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_ctrl <= w_ctrl;
      if (w_go_serial) begin
        r_state     <= S_SHIFT;
        r_work      <= srcA;
        r_cnt       <= w_shamt;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= S_HOLD;
        r_result    <= w_result;
        r_zero      <= (w_result == '0);
        r_illegal   <= (w_ctrl == OP_ILL);
        r_out_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - SHW'(1);
          // Last position shifted: publish directly so latency is 1+shamt
          if (r_cnt == SHW'(1)) begin
            r_state     <= S_HOLD;
            r_result    <= w_step;
            r_zero      <= (w_step == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign ALUResult  = r_result;
  assign ALUControl = r_ctrl;
  assign Zero       = r_zero;
  assign illegal    = r_illegal;

endmodule

// File: doc/alu_decode_pipe.md
# alu_decode_pipe

Handshaked ALU control-decode and execute unit for the RISC-V datapath, the parametrised successor to the combinational ALU decoder. It accepts the decoder fields (opb5, funct3, funct7b5, ALUOp) plus two operands, decodes an extended ALU operation set including shifts and XOR, computes the result, and presents it on a valid/ready output. Shifts execute either in one cycle (barrel) or bit-serially through a state machine, selectable by parameter. It sits between the main decoder/register read stage and writeback in the multi-cycle core.

## Interface
- WIDTH, 32, operand/result width (≥ 8, power of two)
- SERIAL_SHIFT, 1, 1 = one shift position per cycle, 0 = single-cycle barrel shift
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operation present
- in_ready  out  1  block accepts input this cycle
- opb5  in  1  opcode bit 5 (1 = R-type)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction funct7 bit 5
- ALUOp  in  2  main-decoder ALU class
- srcA  in  WIDTH  operand A
- srcB  in  WIDTH  operand B; shift amount is srcB[$clog2(WIDTH)-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- ALUResult  out  WIDTH  result
- ALUControl  out  4  decoded operation of the held result
- Zero  out  1  ALUResult == 0
- illegal  out  1  held operation was undecodable

## Operation
- Decode, captured at accept: ALUOp 00 → add; 01 → sub; 11 → illegal; 10 → by funct3: 000 sub if opb5 & funct7b5 else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if funct7b5 else srl; 110 or; 111 and.
- ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1111 illegal.
- add/sub wrap modulo 2^WIDTH; slt signed compare, sltu unsigned, result zero-extended 0/1; sra replicates srcA MSB; illegal → ALUResult 0, illegal=1.
- Accept = in_valid & in_ready; operands and decode registered at accept.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: in_ready=1. On accept: shift op with SERIAL_SHIFT=1 and shamt≠0 → SHIFT (counter=shamt); otherwise compute → HOLD.
  - SHIFT: in_ready=0; one position per cycle, counter decrements; counter reaching 0 → HOLD.
  - HOLD: out_valid=1. out_ready=0 → stay, all outputs stable. out_ready=1 → result consumed; in_ready=1 in this state when out_ready=1, so a simultaneous accept takes the new op (→ HOLD or SHIFT) with no idle cycle; otherwise → IDLE.
- Zero derives from registered ALUResult.

## Timing
- Reset (reset_n=0 at clk edge): state IDLE, out_valid=0, ALUResult=0, ALUControl=0000, Zero=0, illegal=0, counter=0. Reset mid-SHIFT or mid-HOLD discards the operation; no result is emitted.
- Latency accept → out_valid: 1 cycle for non-shift ops, barrel shifts, and shamt=0; 1+shamt cycles for serial shifts (max WIDTH cycles for shamt=WIDTH-1).
- Throughput: one op per cycle under continuous out_ready=1 for non-serial ops.
- in_ready is combinational from state and out_ready only; it does not depend on in_valid.
- in_valid while in_ready=0 is ignored; inputs need not be held.

## Test plan
- Reset: reset_n=0 for 2 cycles → out_valid=0, in_ready=1, ALUResult=0, ALUControl=0000.
- R-type sub/addi: opb5=1, funct3=000, funct7b5=1, ALUOp=10, A=5, B=7 → next cycle out_valid=1, ALUResult=0xFFFFFFFE, ALUControl=0001; same fields with opb5=0 → ALUResult=12, ALUControl=0000. slt A=0xFFFFFFFF, B=1 → 1; sltu → 0, Zero=1.
- Serial sra: funct3=101, funct7b5=1, ALUOp=10, A=0x80000000, B=4 → in_ready=0 for 4 cycles, out_valid exactly 5 cycles after accept, ALUResult=0xF8000000, ALUControl=1001; SERIAL_SHIFT=0 build → same result after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles in HOLD → outputs stable, in_ready=0; then out_ready=1 with in_valid=1 (xor A=0xFF00FF00, B=0x0F0F0F0F) → accepted same cycle, next cycle ALUResult=0xF00FF00F.
- Illegal: ALUOp=11 → out_valid after 1 cycle, illegal=1, ALUControl=1111, ALUResult=0, Zero=1.
- Reset mid-shift: sll with B=20, reset_n=0 on the 3rd SHIFT cycle → next cycle IDLE, out_valid=0, in_ready=1, no result ever presented.
